regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised multi-port register file; successor to the single-write, two-read CPU register file.
- Configurable data width, depth, read-port count and optional hard-wired zero entry.
- Two write ports with defined same-address priority, plus write-to-read bypass on every read port.
- Hardware bulk-clear sequencer, so software or an exception handler can zero the file without a reset; includes a registered write-conflict flag for debug.

Parameters:
DATA_W, 32, entry width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of combinational read ports (1..4)
ZERO_REG, 1, 1: entry 0 always reads 0 and ignores writes and clear; 0: entry 0 is ordinary storage

Ports:
clk  in  1  single clock, all state updates on posedge
reset  in  1  asynchronous, active-high reset
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W]
wr0_en  in  1  write port 0 enable
wr0_addr  in  ADDR_W  write port 0 address
wr0_data  in  DATA_W  write port 0 data
wr1_en  in  1  write port 1 enable
wr1_addr  in  ADDR_W  write port 1 address
wr1_data  in  DATA_W  write port 1 data
clr_req  in  1  start bulk clear; sampled only in IDLE
clr_busy  out  1  clear sequence in progress
clr_done  out  1  one-cycle pulse when the clear sequence completes
wr_conflict  out  1  registered flag: both write ports hit the same writable address in the previous cycle

Behaviour:
Reset:
- Asserting reset sets all entries to 0, state=IDLE, clr_busy=0, clr_done=0, wr_conflict=0, clear index=first clearable entry. Takes effect immediately, without a clock edge.
- Reset mid-clear aborts the sequence. No clr_done pulse is issued.

Read (combinational, zero latency), per port, in priority order:
- ZERO_REG=1 and addr==0 -> 0.
- wr1_en and wr1_addr==addr -> wr1_data.
- wr0_en and wr0_addr==addr -> wr0_data.
- Otherwise the stored entry.

Write (posedge clk):
- Each enabled port writes its entry.
- Same address on both ports: wr1 wins.
- Writes to entry 0 are dropped when ZERO_REG=1.

wr_conflict:
- Next value = wr0_en & wr1_en & (wr0_addr==wr1_addr) & writable address.
- Updated every cycle; no sticky behaviour.

Clear FSM, states IDLE, CLEAR, DONE:
- IDLE: clr_req=1 at an edge -> CLEAR, index=ZERO_REG.
- CLEAR: clr_busy=1. Each edge zeroes entry[index] and increments index. The edge that clears entry DEPTH-1 -> DONE.
- Clear length: DEPTH-ZERO_REG edges (31 for the defaults).
- DONE: clr_done=1, clr_busy=0. Next edge -> IDLE.
- clr_req is ignored in CLEAR and DONE.
- clr_req held high in IDLE immediately after DONE starts a new sequence.

Clear interaction with writes:
- An external write to the entry being cleared on the same edge wins; the entry holds the write data.
- Entries written after their clear edge keep the written value.
- The clear write is never bypassed to reads. A read of the index entry in its clear cycle returns the pre-clear value.
- External writes and reads remain fully functional during CLEAR.

Width rules:
- Index counter is ADDR_W+1 bits wide to detect the end of the sequence.
- No arithmetic on the data path.

Decomposition:
- Package regfile_pkg:
  - clear-FSM state enum (IDLE, CLEAR, DONE)
  - default-width localparams
  - helper function for packed-slice indexing
- Sub-module regfile_clr_fsm holds the state register, index counter, clr_busy and clr_done. It outputs clr_we and clr_idx to the storage array.
- Storage, write priority and bypass logic stay in regfile_mp.

Test Plan:
1. Reset, then write 0xDEADBEEF to entry 5 via wr0 and 0x12345678 to entry 0 via wr1. Read entries 5 and 0 -> 0xDEADBEEF and 0x00000000; wr_conflict=0.
2. Same cycle: wr0 writes 0xAAAA0000 to entry 7 and wr1 writes 0x0000BBBB to entry 7, rd_addr0=7. Same-cycle read -> 0x0000BBBB (bypass). Next cycle: stored value is 0x0000BBBB and wr_conflict=1. Cycle after that: wr_conflict=0.
3. Fill entries 1..31 with their index value, pulse clr_req at edge T. clr_busy=1 for 31 cycles; clr_done=1 for exactly one cycle after edge T+31; all entries then read 0.
4. During a clear, wr0 writes 0x55 to entry 10 on the edge whose clear index is 10, and 0x66 to entry 3 after entry 3 has been cleared. After clr_done: entry 10=0x55, entry 3=0x66, every other entry=0.
5. Assert reset asynchronously mid-clear, at index 15. Outputs go to 0 immediately; all entries read 0; no clr_done pulse; a subsequent clr_req runs the full 31-cycle sequence.
6. ZERO_REG=0, NUM_RD=4 build: write 0x1 to entry 0 and read it on all four ports -> 0x1. A clear takes 32 cycles and zeroes entry 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   clr_state_e : clear-sequencer states
//   DEF_*       : default widths and configuration
//   slice_lo    : low bit of element k in a packed bus of w-bit elements
package regfile_pkg;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_ADDR_W   = 5;
   localparam int DEF_NUM_RD   = 2;
   localparam int DEF_ZERO_REG = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } clr_state_e;

   function automatic int slice_lo(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// Bulk-clear sequencer for the register file. Walks an index over every
// clearable entry, one entry per clock, then pulses clr_done for one cycle.
//   clk, reset : clock, asynchronous active-high reset
//   clr_req    : start request, only honoured in IDLE
//   clr_busy   : sequence in progress
//   clr_done   : one-cycle completion pulse
//   clr_we     : zero the entry at clr_idx on this edge
//   clr_idx    : entry being cleared
//
// state | meaning
// IDLE  | waiting for clr_req
// CLEAR | zeroing entry[idx] each edge, idx counts up to DEPTH-1
// DONE  | one-cycle completion pulse, then back to IDLE
module regfile_clr_fsm
   import regfile_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_REG = DEF_ZERO_REG
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_idx
);

   localparam int DEPTH = 2 ** ADDR_W;
   // One extra index bit so the counter can step past DEPTH-1 in DONE
   // without wrapping back onto a valid entry.
   localparam logic [ADDR_W:0] IDX_FIRST = (ZERO_REG != 0) ? (ADDR_W+1)'(1) : '0;
   localparam logic [ADDR_W:0] IDX_LAST  = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] IDX_ONE   = (ADDR_W+1)'(1);

   clr_state_e      state, state_nxt;
   logic [ADDR_W:0] idx, idx_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         idx   <= IDX_FIRST;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         IDLE: begin
            if (clr_req) begin
               state_nxt = CLEAR;
               idx_nxt   = IDX_FIRST;
            end
         end
         CLEAR: begin
            idx_nxt = idx + IDX_ONE;
            if (idx == IDX_LAST) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      clr_busy = (state == CLEAR);
      clr_done = (state == DONE);
      clr_we   = (state == CLEAR);
      clr_idx  = idx[ADDR_W-1:0];
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports (wr1 wins on the same address),
// NUM_RD combinational read ports with write-to-read bypass, optional
// hard-wired zero entry, hardware bulk clear and a registered
// write-conflict flag.
//   clk, reset          : clock, asynchronous active-high reset
//   rd_addr / rd_data   : packed read ports, port k at slice k
//   wr0_* / wr1_*       : write ports
//   clr_req             : start bulk clear
//   clr_busy / clr_done : clear status
//   wr_conflict         : both write ports hit the same writable entry last cycle
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int ZERO_REG = DEF_ZERO_REG
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic                     wr0_en,
   input  logic [ADDR_W-1:0]        wr0_addr,
   input  logic [DATA_W-1:0]        wr0_data,
   input  logic                     wr1_en,
   input  logic [ADDR_W-1:0]        wr1_addr,
   input  logic [DATA_W-1:0]        wr1_data,
   input  logic                     clr_req,
   output logic                     clr_busy,
   output logic                     clr_done,
   output logic                     wr_conflict
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              clr_we;
   logic [ADDR_W-1:0] clr_idx;
   logic              wr0_ok, wr1_ok, clr_ok;

   function automatic logic writable(input logic [ADDR_W-1:0] a);
      return (ZERO_REG == 0) || (a != '0);
   endfunction

   regfile_clr_fsm #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_clr_fsm (
      .clk      (clk),
      .reset    (reset),
      .clr_req  (clr_req),
      .clr_busy (clr_busy),
      .clr_done (clr_done),
      .clr_we   (clr_we),
      .clr_idx  (clr_idx)
   );

   assign wr0_ok = wr0_en & writable(wr0_addr);
   assign wr1_ok = wr1_en & writable(wr1_addr);
   assign clr_ok = clr_we & writable(clr_idx);

   // Later assignments win: clear < wr0 < wr1.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (clr_ok) mem[clr_idx]  <= '0;
         if (wr0_ok) mem[wr0_addr] <= wr0_data;
         if (wr1_ok) mem[wr1_addr] <= wr1_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) wr_conflict <= 1'b0;
      else       wr_conflict <= wr0_ok & wr1_ok & (wr0_addr == wr1_addr);
   end

   // The clear write is deliberately not bypassed: a read of the entry being
   // cleared sees the old value until the edge.
   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] val;

      assign a = rd_addr[slice_lo(k, ADDR_W) +: ADDR_W];

      always_comb begin
         if ((ZERO_REG != 0) && (a == '0))  val = '0;
         else if (wr1_en && wr1_addr == a)  val = wr1_data;
         else if (wr0_en && wr0_addr == a)  val = wr0_data;
         else                               val = mem[a];
      end

      assign rd_data[slice_lo(k, DATA_W) +: DATA_W] = val;
   end

endmodule
